// File: rtl/writeback_module_pkg.sv
// Shared constants and types for the writeback stage.
//   DATA_W : memory beat / scalar register width
//   VEC_W  : vector register width
//   BEATS  : beats per vector load (VEC_W / DATA_W)
//   ADDR_W : register address width
//   CNT_W  : width of a beat count able to hold 0..BEATS
package writeback_module_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned VEC_W  = 128;
    localparam int unsigned BEATS  = VEC_W / DATA_W;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned CNT_W  = $clog2(BEATS + 1);

    typedef enum logic [0:0] {
        IDLE,
        COLLECT
    } wb_state_t;

    // Command of the load currently being collected
    typedef struct packed {
        logic              wreg;
        logic              vf;
        logic [ADDR_W-1:0] dest;
    } wb_cmd_t;

    // Number of memory beats a load must collect
    function automatic logic [CNT_W-1:0] beats_needed(input logic vf);
        return vf ? CNT_W'(BEATS) : CNT_W'(1);
    endfunction

endpackage

// File: rtl/writeback_module_if.sv
// MEM-stage to writeback bundle.
//   master : upstream / environment side (drives the MEM-stage and memory-beat signals,
//            receives stall and the register-file write port)
//   slave  : the writeback stage
interface writeback_module_if;
    import writeback_module_pkg::*;

    logic              in_valid;
    logic              wreg_m;
    logic              rmem_m;
    logic              vf_m;
    logic [ADDR_W-1:0] dest_m;
    logic [VEC_W-1:0]  alu_res_m;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;
    logic              stall;
    logic              wb_en;
    logic              wb_vf;
    logic [ADDR_W-1:0] wb_dest;
    logic [VEC_W-1:0]  wb_data;

    modport master (
        output in_valid, wreg_m, rmem_m, vf_m, dest_m, alu_res_m, mem_rdata, mem_rvalid,
        input  stall, wb_en, wb_vf, wb_dest, wb_data
    );

    modport slave (
        input  in_valid, wreg_m, rmem_m, vf_m, dest_m, alu_res_m, mem_rdata, mem_rvalid,
        output stall, wb_en, wb_vf, wb_dest, wb_data
    );

endinterface

// File: rtl/writeback_module_assembler.sv
// Lane-insert buffer and beat counter for multi-beat loads.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : start a new load (buffer and count restart from zero this cycle)
//   beat_valid : beat_data is a beat of the current load
//   beat_data  : memory beat, stored into lane <count>
//   need       : beats required by the current load
//   done       : this beat completes the load
//   vec_out    : assembled vector including the current beat (valid with done)
module vector_beat_assembler
    import writeback_module_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              beat_valid,
    input  logic [DATA_W-1:0] beat_data,
    input  logic [CNT_W-1:0]  need,
    output logic              done,
    output logic [VEC_W-1:0]  vec_out
);

    logic [VEC_W-1:0] vec_q, vec_d, vec_base;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;

    always_comb begin
        // A clear coincides with beat 0 when the load's first beat arrives in its accept cycle
        vec_base = clear ? '0 : vec_q;
        cnt_base = clear ? '0 : cnt_q;
        vec_d    = vec_base;
        cnt_d    = cnt_base;
        done     = 1'b0;
        if (beat_valid && (cnt_base < CNT_W'(BEATS))) begin
            for (int unsigned k = 0; k < BEATS; k++) begin
                if (cnt_base == CNT_W'(k)) begin
                    vec_d[k*DATA_W +: DATA_W] = beat_data;
                end
            end
            cnt_d = cnt_base + CNT_W'(1);
            done  = (cnt_d == need);
        end
    end

    assign vec_out = vec_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q <= '0;
            cnt_q <= '0;
        end else begin
            vec_q <= vec_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/writeback_module.sv
// Writeback stage: registers MEM-stage results into the register-file write port, choosing
// between the ALU result and load data. Loads collect 1 (scalar) or BEATS (vector) memory
// beats while holding upstream stalled, then issue a single write.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of writeback_module_if
//                in : in_valid, wreg_m, rmem_m, vf_m, dest_m, alu_res_m, mem_rdata, mem_rvalid
//                out: stall (combinational), wb_en, wb_vf, wb_dest, wb_data (registered)
module writeback_module
    import writeback_module_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    writeback_module_if.slave  bus
);

    wb_state_t         state_q, state_d;
    wb_cmd_t           cmd_q, cmd_d, cmd_cur;
    logic              accept;
    logic              beat_valid;
    logic              asm_done;
    logic [CNT_W-1:0]  need;
    logic [VEC_W-1:0]  asm_vec;

    logic              wb_en_q, wb_en_d;
    logic              wb_vf_q, wb_vf_d;
    logic [ADDR_W-1:0] wb_dest_q, wb_dest_d;
    logic [VEC_W-1:0]  wb_data_q, wb_data_d;

    always_comb begin
        accept  = (state_q == IDLE) && bus.in_valid && bus.rmem_m;
        // In the accept cycle the latch is not loaded yet, so use the live command
        cmd_cur = accept ? wb_cmd_t'{wreg: bus.wreg_m, vf: bus.vf_m, dest: bus.dest_m}
                         : cmd_q;
        need       = beats_needed(cmd_cur.vf);
        beat_valid = bus.mem_rvalid && (accept || (state_q == COLLECT));
    end

    assign bus.stall = accept || (state_q == COLLECT);

    vector_beat_assembler u_assembler (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (accept),
        .beat_valid (beat_valid),
        .beat_data  (bus.mem_rdata),
        .need       (need),
        .done       (asm_done),
        .vec_out    (asm_vec)
    );

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        wb_en_d   = 1'b0;
        wb_vf_d   = wb_vf_q;
        wb_dest_d = wb_dest_q;
        wb_data_d = wb_data_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && !bus.rmem_m) begin
                    wb_en_d   = bus.wreg_m;
                    wb_vf_d   = bus.vf_m;
                    wb_dest_d = bus.dest_m;
                    wb_data_d = bus.vf_m ? bus.alu_res_m
                                         : {{(VEC_W-DATA_W){1'b0}}, bus.alu_res_m[DATA_W-1:0]};
                end else if (accept) begin
                    cmd_d = cmd_cur;
                    if (asm_done) begin
                        // Scalar load whose only beat arrived with the instruction
                        wb_en_d   = cmd_cur.wreg;
                        wb_vf_d   = cmd_cur.vf;
                        wb_dest_d = cmd_cur.dest;
                        wb_data_d = asm_vec;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (asm_done) begin
                    wb_en_d   = cmd_cur.wreg;
                    wb_vf_d   = cmd_cur.vf;
                    wb_dest_d = cmd_cur.dest;
                    wb_data_d = asm_vec;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            wb_en_q   <= 1'b0;
            wb_vf_q   <= 1'b0;
            wb_dest_q <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            wb_en_q   <= wb_en_d;
            wb_vf_q   <= wb_vf_d;
            wb_dest_q <= wb_dest_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign bus.wb_en   = wb_en_q;
    assign bus.wb_vf   = wb_vf_q;
    assign bus.wb_dest = wb_dest_q;
    assign bus.wb_data = wb_data_q;

endmodule
